// File: rtl/urv_console_pkg.sv
// Shared definitions for the uRV console UART: register offsets, STATUS bit
// positions and the serialiser state encoding.
package urv_console_pkg;

  localparam logic [3:0] C_OFF_TX     = 4'h0;
  localparam logic [3:0] C_OFF_DONE   = 4'h4;
  localparam logic [3:0] C_OFF_STATUS = 4'h8;
  localparam logic [3:0] C_OFF_RSVD   = 4'hC;

  localparam int unsigned C_STAT_FULL = 0;
  localparam int unsigned C_STAT_IDLE = 1;
  localparam int unsigned C_STAT_DONE = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } t_tx_state;

endpackage

// File: rtl/urv_console_uart_if.sv
// uRV data-memory port as seen by the console slave; signal names keep the
// slave-side direction suffixes so the top-level names read the same.
interface urv_console_uart_if;

  logic [31:0] dm_addr_i;
  logic [31:0] dm_data_s_i;
  logic [3:0]  dm_data_select_i;
  logic        dm_store_i;
  logic        dm_load_i;
  logic [31:0] dm_data_l_o;
  logic        dm_store_done_o;
  logic        dm_load_done_o;

  modport master (
    output dm_addr_i, dm_data_s_i, dm_data_select_i, dm_store_i, dm_load_i,
    input  dm_data_l_o, dm_store_done_o, dm_load_done_o
  );

  modport slave (
    input  dm_addr_i, dm_data_s_i, dm_data_select_i, dm_store_i, dm_load_i,
    output dm_data_l_o, dm_store_done_o, dm_load_done_o
  );

endinterface

// File: rtl/urv_console_fifo.sv
// TX byte buffer. With URV_CONSOLE_FIFO_EN defined it is a g_depth-entry FIFO,
// otherwise a single holding register. A push while full is taken only with a pop.
module urv_console_fifo #(
  parameter int unsigned g_depth = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);

  logic w_push_en;
  logic w_pop_en;

`ifdef URV_CONSOLE_FIFO_EN
  localparam int unsigned C_AW = $clog2(g_depth);

  logic [C_AW:0] r_wr_ptr;
  logic [C_AW:0] r_rd_ptr;
  logic [7:0]    r_mem [g_depth];

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                     (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
  assign o_data    = r_mem[r_rd_ptr[C_AW-1:0]];
  assign w_push_en = i_push && (!o_full || i_pop);
  assign w_pop_en  = i_pop && !o_empty;

  // Read/write pointers, one extra wrap bit to tell full from empty.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= {(C_AW+1){1'b0}};
      r_rd_ptr <= {(C_AW+1){1'b0}};
    end else begin
      if (w_push_en) r_wr_ptr <= r_wr_ptr + {{C_AW{1'b0}}, 1'b1};
      if (w_pop_en)  r_rd_ptr <= r_rd_ptr + {{C_AW{1'b0}}, 1'b1};
    end
  end

  // Storage array.
  always_ff @(posedge clk_i) begin
    if (w_push_en) r_mem[r_wr_ptr[C_AW-1:0]] <= i_data;
  end
`else
  logic       r_occ;
  logic [7:0] r_hold;

  assign o_full    = r_occ;
  assign o_empty   = !r_occ;
  assign o_data    = r_hold;
  assign w_push_en = i_push && (!r_occ || i_pop);
  assign w_pop_en  = i_pop && r_occ;

  // Single holding register; a push with a pop simply replaces the byte.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_occ  <= 1'b0;
      r_hold <= 8'd0;
    end else if (w_push_en) begin
      r_occ  <= 1'b1;
      r_hold <= i_data;
    end else if (w_pop_en) begin
      r_occ  <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/urv_console_uart.sv
// Memory-mapped console UART and test-done latch on the uRV data port.
// Optional macro URV_CONSOLE_FIFO_EN selects a deep TX FIFO over a holding register.
module urv_console_uart
  import urv_console_pkg::*;
#(
  parameter logic [31:0] g_base_addr  = 32'h0010_0000,
  parameter int unsigned g_clk_div    = 868,
  parameter int unsigned g_fifo_depth = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  urv_console_uart_if.slave  dm,
  output logic               uart_txd_o,
  output logic               test_done_o,
  output logic [31:0]        test_code_o
);

  localparam logic [15:0] C_DIV_RELOAD = 16'(g_clk_div - 1);

  logic        w_hit;
  logic [3:0]  w_off;
  logic        w_store_acc;
  logic        w_load_acc;
  logic        w_tx_store;
  logic        w_want_push;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [7:0]  w_push_data;
  logic [7:0]  w_fifo_data;
  logic [31:0] w_status;
  logic [31:0] w_rd_data;

  logic        r_pend;
  logic [7:0]  r_pend_data;
  logic        r_store_done;
  logic        r_load_done;
  logic [31:0] r_data_l;
  logic        r_test_done;
  logic [31:0] r_test_code;

  t_tx_state   r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_txd;

  // A pending (stalled) TX store blocks any new strobe until it is pushed.
  assign w_hit       = (dm.dm_addr_i[31:4] == g_base_addr[31:4]);
  assign w_off       = {dm.dm_addr_i[3:2], 2'b00};
  assign w_store_acc = dm.dm_store_i && w_hit && !r_pend;
  assign w_load_acc  = dm.dm_load_i && w_hit && !r_pend;
  assign w_tx_store  = w_store_acc && (w_off == C_OFF_TX) && dm.dm_data_select_i[0];
  assign w_want_push = r_pend || w_tx_store;
  assign w_push_data = r_pend ? r_pend_data : dm.dm_data_s_i[7:0];
  assign w_push      = w_want_push && (!w_full || w_pop);
  assign w_pop       = !w_empty && ((r_state == ST_IDLE) ||
                                    ((r_state == ST_STOP) && (r_cnt == 16'd0)));

  always_comb begin
    w_status              = 32'd0;
    w_status[C_STAT_FULL] = w_full;
    w_status[C_STAT_IDLE] = w_empty && (r_state == ST_IDLE);
    w_status[C_STAT_DONE] = r_test_done;
  end

  // Load data selection by register offset.
  always_comb begin
    w_rd_data = 32'd0;
    case (w_off)
      C_OFF_DONE:   w_rd_data = r_test_code;
      C_OFF_STATUS: w_rd_data = w_status;
      default:      w_rd_data = 32'd0;
    endcase
  end

  urv_console_fifo #(
    .g_depth (g_fifo_depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Bus responses, stalled-store holding and the test-done latch.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pend       <= 1'b0;
      r_pend_data  <= 8'd0;
      r_store_done <= 1'b0;
      r_load_done  <= 1'b0;
      r_data_l     <= 32'd0;
      r_test_done  <= 1'b0;
      r_test_code  <= 32'd0;
    end else begin
      r_pend       <= w_want_push && !w_push;
      r_store_done <= w_push || (w_store_acc && !w_tx_store);
      r_load_done  <= w_load_acc;
      if (w_tx_store) r_pend_data <= dm.dm_data_s_i[7:0];
      if (w_load_acc) r_data_l <= w_rd_data;
      if (w_store_acc && (w_off == C_OFF_DONE)) begin
        r_test_done <= 1'b1;
        r_test_code <= dm.dm_data_s_i;
      end
    end
  end

  // 8N1 serialiser; every non-idle bit lasts g_clk_div cycles, STOP chains into START.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_txd   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_state <= ST_START;
            r_shift <= w_fifo_data;
            r_cnt   <= C_DIV_RELOAD;
            r_txd   <= 1'b0;
          end
        end
        ST_START: begin
          if (r_cnt == 16'd0) begin
            r_state <= ST_DATA;
            r_cnt   <= C_DIV_RELOAD;
            r_bit   <= 3'd0;
            r_txd   <= r_shift[0];
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (r_cnt == 16'd0) begin
            r_cnt <= C_DIV_RELOAD;
            if (r_bit == 3'd7) begin
              r_state <= ST_STOP;
              r_txd   <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_txd   <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        ST_STOP: begin
          if (r_cnt == 16'd0) begin
            if (w_pop) begin
              r_state <= ST_START;
              r_shift <= w_fifo_data;
              r_cnt   <= C_DIV_RELOAD;
              r_txd   <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

  assign uart_txd_o         = r_txd;
  assign test_done_o        = r_test_done;
  assign test_code_o        = r_test_code;
  assign dm.dm_data_l_o     = r_data_l;
  assign dm.dm_store_done_o = r_store_done;
  assign dm.dm_load_done_o  = r_load_done;

endmodule

// File: tb/tb_urv_console_uart.sv
// Self-checking bench for urv_console_uart: bus model, UART receiver model and
// expected-byte queue; follows URV_CONSOLE_FIFO_EN for the buffer depth.
module tb_urv_console_uart;

  localparam int unsigned C_DIV  = 4;
`ifdef URV_CONSOLE_FIFO_EN
  localparam int          C_DEPTH = 16;
`else
  localparam int          C_DEPTH = 1;
`endif
  localparam logic [31:0] C_BASE = 32'h0010_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_txd;
  logic        test_done;
  logic [31:0] test_code;

  urv_console_uart_if bus ();

  urv_console_uart #(
    .g_base_addr  (C_BASE),
    .g_clk_div    (C_DIV),
    .g_fifo_depth (16)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .dm          (bus),
    .uart_txd_o  (uart_txd),
    .test_done_o (test_done),
    .test_code_o (test_code)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_frames = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_code = 32'd0;
  logic [7:0]  exp_q[$];
  int          starts_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of the test-done outputs against the model; idle line in reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("test_done_o", {31'd0, test_done}, {31'd0, m_done});
      check("test_code_o", test_code, m_code);
    end else begin
      check("txd in reset", {31'd0, uart_txd}, 32'd1);
    end
  end

  // UART receiver: samples each bit one cycle after its start, checks framing and order.
  initial begin : rx_proc
    int t0;
    logic [9:0] bits;
    bit ab;
    forever begin
      @(negedge clk);
      if (rst_n && uart_txd === 1'b0) begin
        t0 = cyc;
        ab = 1'b0;
        bits = 10'd0;
        for (int j = 1; j < 10 * C_DIV; j++) begin
          @(negedge clk);
          if (!rst_n) ab = 1'b1;
          if (j % C_DIV == 1) bits[j / C_DIV] = uart_txd;
        end
        if (!ab) begin
          starts_q.push_back(t0);
          n_frames++;
          check("rx start bit", {31'd0, bits[0]}, 32'd0);
          check("rx stop bit", {31'd0, bits[9]}, 32'd1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx unexpected frame: got byte 0x%02h, expected no frame", bits[8:1]);
          end else begin
            check("rx data byte", {24'd0, bits[8:1]}, {24'd0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] sel, input int budget, output int lat);
    @(posedge clk); #1;
    bus.dm_addr_i        = addr;
    bus.dm_data_s_i      = data;
    bus.dm_data_select_i = sel;
    bus.dm_store_i       = 1'b1;
    @(posedge clk); #1;
    bus.dm_store_i = 1'b0;
    if ((addr >> 4) == (C_BASE >> 4)) begin
      if (((addr >> 2) & 32'd3) == 32'd1) begin
        m_done = 1'b1;
        m_code = data;
      end
      if ((((addr >> 2) & 32'd3) == 32'd0) && sel[0]) exp_q.push_back(data[7:0]);
    end
    lat = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.dm_store_done_o === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic do_load(input logic [31:0] addr, input int budget,
                         output logic [31:0] data, output int lat);
    @(posedge clk); #1;
    bus.dm_addr_i = addr;
    bus.dm_load_i = 1'b1;
    @(posedge clk); #1;
    bus.dm_load_i = 1'b0;
    lat  = 0;
    data = 32'd0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.dm_load_done_o === 1'b1) begin
        lat  = i;
        data = bus.dm_data_l_o;
        break;
      end
    end
  endtask

  task automatic load_check(input logic [31:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] d;
    int lat;
    do_load(addr, 10, d, lat);
    check({name, " load latency"}, lat, 32'd1);
    check({name, " load data"}, d, exp);
    @(negedge clk);
    check({name, " load_done pulse"}, {31'd0, bus.dm_load_done_o}, 32'd0);
    check({name, " load data hold"}, bus.dm_data_l_o, exp);
  endtask

  task automatic idle_check(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(name, {31'd0, uart_txd}, 32'd1);
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : main
    int          lat;
    int          t_fall;
    logic [31:0] code;
    logic [31:0] data;
    logic [7:0]  b;
    logic [3:0]  sel;
    logic [9:0]  pat;

    bus.dm_addr_i        = 32'd0;
    bus.dm_data_s_i      = 32'd0;
    bus.dm_data_select_i = 4'd0;
    bus.dm_store_i       = 1'b0;
    bus.dm_load_i        = 1'b0;

    // Reset values
    repeat (4) @(negedge clk);
    check("reset txd", {31'd0, uart_txd}, 32'd1);
    check("reset store_done", {31'd0, bus.dm_store_done_o}, 32'd0);
    check("reset load_done", {31'd0, bus.dm_load_done_o}, 32'd0);
    check("reset load data", bus.dm_data_l_o, 32'd0);
    check("reset test_done", {31'd0, test_done}, 32'd0);
    check("reset test_code", test_code, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_check(50, "idle after reset");
    load_check(C_BASE + 32'h8, 32'h2, "status after reset");

    // Single byte 0x41: exact line timing and bit pattern
    do_store(C_BASE, 32'h0000_0041, 4'b0001, 10, lat);
    check("tx store latency", lat, 32'd1);
    check("txd before start", {31'd0, uart_txd}, 32'd1);
    @(negedge clk);
    check("txd falls two cycles after store", {31'd0, uart_txd}, 32'd0);
    pat = 10'b1010000010;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check("0x41 line bit", {31'd0, uart_txd}, {31'd0, pat[k]});
      repeat (C_DIV) @(negedge clk);
    end
    load_check(C_BASE + 32'h8, 32'h2, "status idle after frame");

    // Burst of 20 random bytes: stall pattern, order, no gaps
    starts_q.delete();
    n_frames = 0;
    for (int i = 0; i < 20; i++) begin
      b    = 8'($urandom_range(0, 255));
      sel  = 4'($urandom_range(0, 15)) | 4'b0001;
      data = {$urandom_range(0, 32'h00FF_FFFF), 8'd0} | {24'd0, b};
      do_store(C_BASE, data, sel, 200, lat);
      if (i <= C_DEPTH) check("burst store accepted at once", lat, 32'd1);
      else              check("burst store stalled", {31'd0, lat > 1}, 32'd1);
    end
    load_check(C_BASE + 32'h8, 32'h1, "status full during burst");
    repeat (20 * 10 * C_DIV + 100) @(negedge clk);
    check("burst frames received", n_frames, 32'd20);
    check("burst queue drained", exp_q.size(), 32'd0);
    for (int i = 1; i < starts_q.size(); i++)
      check("burst frame spacing", starts_q[i] - starts_q[i-1], 10 * C_DIV);

    // Test-done register
    do_store(C_BASE + 32'h4, 32'hCAFE_0001, 4'hF, 10, lat);
    check("done store latency", lat, 32'd1);
    @(negedge clk);
    check("store_done pulse", {31'd0, bus.dm_store_done_o}, 32'd0);
    check("test_code literal", test_code, 32'hCAFE_0001);
    load_check(C_BASE + 32'h4, 32'hCAFE_0001, "done readback");
    load_check(C_BASE + 32'h8, 32'h6, "status with done");
    load_check(C_BASE, 32'h0, "tx readback");
    load_check(C_BASE + 32'hC, 32'h0, "reserved readback");
    code = $urandom();
    do_store(C_BASE + 32'h4, code, 4'hF, 10, lat);
    check("done overwrite latency", lat, 32'd1);
    load_check(C_BASE + 32'h4, code, "done overwrite readback");

    // Stores that must not push
    do_store(C_BASE, 32'h0000_0055, 4'b0010, 10, lat);
    check("tx store without lane0 latency", lat, 32'd1);
    do_store(C_BASE + 32'hC, 32'hFFFF_FFFF, 4'hF, 10, lat);
    check("reserved store latency", lat, 32'd1);
    do_store(C_BASE + 32'h8, 32'hFFFF_FFFF, 4'hF, 10, lat);
    check("status store latency", lat, 32'd1);
    idle_check(60, "line idle after non-push stores");
    load_check(C_BASE + 32'h8, 32'h6, "status unchanged");

    // Outside the window: no response at all
    do_store(32'h0020_0004, 32'h1234_5678, 4'hF, 20, lat);
    check("out-of-window store no done", lat, 32'd0);
    do_store(32'h0020_0000, 32'h0000_00AA, 4'hF, 20, lat);
    check("out-of-window tx store no done", lat, 32'd0);
    do_load(32'h0010_1008, 20, data, lat);
    check("out-of-window load no done", lat, 32'd0);
    idle_check(20, "line idle after out-of-window");

    // Reset in the middle of DATA bit 3, with more bytes queued
    b = 8'($urandom_range(0, 255)) & 8'hF7;
    do_store(C_BASE, {24'd0, b}, 4'b0001, 10, lat);
    check("pre-reset store latency", lat, 32'd1);
    t_fall = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uart_txd === 1'b0) begin
        t_fall = cyc;
        break;
      end
    end
    check("pre-reset frame started", {31'd0, t_fall >= 0}, 32'd1);
    do_store(C_BASE, {24'd0, 8'($urandom_range(0, 255))}, 4'b0001, 10, lat);
    do_store(C_BASE, {24'd0, 8'($urandom_range(0, 255))}, 4'b0001, 10, lat);
    while (cyc < t_fall + 4 * C_DIV + 1) @(negedge clk);
    check("data bit 3 before reset", {31'd0, uart_txd}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("txd high immediately on reset", {31'd0, uart_txd}, 32'd1);
    exp_q.delete();
    m_done = 1'b0;
    m_code = 32'd0;
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    load_check(C_BASE + 32'h8, 32'h2, "status after mid-frame reset");
    idle_check(60, "line idle after mid-frame reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/urv_console_uart.md
# urv_console_uart

Memory-mapped console and test-control slave attached to the uRV data-memory port, downstream of `urv_cpu`. It accepts byte writes to a TX register, buffers them, and serialises them as 8N1 UART on `uart_txd_o`. A test-done register latches a completion code for the bench or board controller, and a status register lets firmware poll the block.

## Interface
Parameters:
- `g_base_addr`, `32'h0010_0000`: base of the 16-byte register window; decode on `dm_addr_i[31:4] == g_base_addr[31:4]`.
- `g_clk_div`, `868`: clock cycles per UART bit; legal range 2..65535.
- `g_fifo_depth`, `16`: TX FIFO entries; must be a power of two, ≥2.

Ports:
- `clk_i` in 1: system clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `dm_addr_i` in 32: CPU data address.
- `dm_data_s_i` in 32: store data.
- `dm_data_select_i` in 4: byte enables.
- `dm_store_i` in 1: store strobe, single cycle.
- `dm_load_i` in 1: load strobe, single cycle.
- `dm_data_l_o` out 32: load data.
- `dm_store_done_o` out 1: store accepted.
- `dm_load_done_o` out 1: load data valid.
- `uart_txd_o` out 1: serial output, idle high.
- `test_done_o` out 1: sticky completion flag.
- `test_code_o` out 32: completion code.

## Operation
Registers, by offset:
- +0x0 TX (write-only): if `dm_data_select_i[0]` is set, push `dm_data_s_i[7:0]`; otherwise the store is ignored.
- +0x4 DONE (write): set `test_done_o`, latch the full 32-bit `dm_data_s_i` into `test_code_o`. A later write overwrites the code; the flag stays set.
- +0x8 STATUS (read): bit0 = FIFO full, bit1 = TX idle (FIFO empty and serialiser in IDLE), bit2 = `test_done_o`, other bits 0.
- +0xC: reserved; reads return 0, writes are ignored.

Bus rules:
- Reads of TX return 0. Reads of DONE return `test_code_o`.
- Strobes outside the window: no response, all done outputs 0.

Serialiser FSM, IDLE → START → DATA → STOP → IDLE:
- IDLE: if the FIFO is non-empty, pop one byte into the shift register and go to START.
- START: drive 0.
- DATA: drive 8 bits, LSB first, with a 3-bit bit counter.
- STOP: drive 1.
- Each state other than IDLE lasts exactly `g_clk_div` cycles, counted by a 16-bit down-counter reloaded on every bit.
- In STOP, if the FIFO is non-empty at the final count, pop and go straight to START, giving back-to-back frames with no idle gap.

## Timing
Reset values:
- `uart_txd_o` = 1.
- `test_done_o` = 0, `test_code_o` = 0.
- `dm_data_l_o` = 0.
- Both done outputs = 0.
- FIFO empty, FSM in IDLE.

Loads:
- `dm_load_done_o` pulses one cycle after `dm_load_i`.
- `dm_data_l_o` is registered and valid during that pulse, then holds its value.

Stores:
- `dm_store_done_o` pulses one cycle after an accepted store.
- A TX store while the FIFO is full is held internally, and `dm_store_done_o` stays 0 until a pop frees a slot. The push and the done pulse occur in the cycle after the pop.
- The CPU must not issue a new strobe before done; a strobe during a pending store is ignored.

Simultaneous events:
- Push and pop in the same cycle on a non-full FIFO: both happen, occupancy unchanged.
- Push while full coincident with a pop: accepted that cycle.
- FIFO pointers are log2(depth)+1 bits and wrap naturally.

First-byte latency: push at cycle N → FIFO non-empty at N+1 → START begins (`uart_txd_o` falls) at N+2.

Reset mid-frame: `uart_txd_o` returns to 1 immediately (asynchronous). The partial frame and FIFO contents are discarded.

## Configuration
- `URV_CONSOLE_FIFO_EN` defined: TX buffer is a FIFO of `g_fifo_depth` entries.
- Not defined: TX buffer is a single holding register (depth 1). `g_fifo_depth` is ignored. STATUS bit0 = holding register occupied. All other behaviour, including stall-on-full, is identical.

## Structure
- `urv_console_pkg` holds:
  - the register offset constants (`TX`, `DONE`, `STATUS`);
  - the STATUS bit indices;
  - the serialiser state enum `t_tx_state`.
- Sub-module `urv_console_fifo`: synchronous FIFO with push/pop/full/empty. The holding-register variant is selected inside it by `URV_CONSOLE_FIFO_EN`.

## Test plan
All scenarios use `g_clk_div` = 4.
- Reset, then idle 50 cycles → `uart_txd_o` = 1, STATUS read = 0x2, `test_done_o` = 0.
- Store 0x41 to 0x100000 → `uart_txd_o` falls 2 cycles later; the line samples as 0, 1,0,0,0,0,0,1,0, 1 at 4-cycle spacing; STATUS bit1 returns to 1 after 40 cycles.
- Store 20 bytes back-to-back (FIFO depth 16) → stores 18..20 stall `dm_store_done_o` until pops; the line shows 20 contiguous frames (800 cycles, no gap) in the correct order.
- Store 0xCAFE0001 to 0x100004, then load 0x100004 and 0x100008 → `test_code_o` = 0xCAFE0001; loads return 0xCAFE0001 and 0x6, each with a one-cycle `dm_load_done_o`.
- Store to 0x100000 with `dm_data_select_i` = 4'b0010 → no push, store done pulses, line stays idle.
- Assert `rst_n_i` during DATA bit 3 → `uart_txd_o` = 1 within the same cycle, FIFO empty, STATUS = 0x2 after release.
